pong_ball_engine: RTL



---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_paddle_hit.sv | 30 +++
 rtl/pong_ball_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared state encoding and playfield/paddle geometry for the pong game logic,
// also used by the renderer and the paddle scaler.
package pong_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_e;

    // Geometry is 12 bits wide so collision sums never wrap.
    localparam logic [11:0] SCREEN_W   = 12'd640;
    localparam logic [11:0] SCREEN_H   = 12'd480;
    localparam logic [11:0] BALL_SIZE  = 12'd10;
    localparam logic [11:0] BALL_SPEED = 12'd2;
    localparam logic [11:0] P1_X       = 12'd20;
    localparam logic [11:0] P2_X       = 12'd610;
    localparam logic [11:0] PADDLE_W   = 12'd10;
    localparam logic [11:0] PADDLE_H   = 12'd50;

    localparam logic [11:0] BALL_X0 = (SCREEN_W - BALL_SIZE) / 12'd2;
    localparam logic [11:0] BALL_Y0 = (SCREEN_H - BALL_SIZE) / 12'd2;

    localparam logic [3:0] WIN_SCORE    = 4'd10;
    localparam logic [5:0] SERVE_FRAMES = 6'd60;

endpackage

// File: rtl/pong_paddle_hit.sv
// Detects the ball crossing a paddle face this frame while vertically
// overlapping the paddle; one instance per paddle.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter bit          FACE_LEFT = 1'b1,
    parameter logic [11:0] FACE_X    = 12'd30
) (
    input  logic        approaching,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic [11:0] paddle_y,
    output logic        hit
);

    logic crossing;
    logic overlap;

    // A left face is met by the ball's left edge, a right face by its leading edge.
    always_comb begin
        if (FACE_LEFT)
            crossing = (ball_x >= FACE_X) && (ball_x < FACE_X + BALL_SPEED);
        else
            crossing = (ball_x + BALL_SIZE <= FACE_X) &&
                       (ball_x + BALL_SIZE + BALL_SPEED > FACE_X);
        overlap = (ball_y + BALL_SIZE > paddle_y) && (ball_y < paddle_y + PADDLE_H);
        hit     = approaching && crossing && overlap;
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong game logic: ball motion, wall/paddle bounces, scoring and game state,
// advanced once per frame tick.
module pong_ball_engine
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic [1:0]  state,
    output logic        score_pulse
);

    game_state_e state_q;
    logic [5:0]  serve_cnt;
    logic        dx_right, dy_down;
    logic [11:0] bx, by, p1y, p2y, x_next, y_next;
    logic        dx_next, dy_next, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]  p1_inc, p2_inc;

    assign bx    = {1'b0, ball_x};
    assign by    = {2'b00, ball_y};
    assign p1y   = {2'b00, p1_y};
    assign p2y   = {2'b00, p2_y};
    assign state = state_q;

    pong_paddle_hit #(.FACE_LEFT(1'b1), .FACE_X(P1_X + PADDLE_W)) u_hit_left (
        .approaching(!dx_right), .ball_x(bx), .ball_y(by), .paddle_y(p1y), .hit(hit_l)
    );

    pong_paddle_hit #(.FACE_LEFT(1'b0), .FACE_X(P2_X)) u_hit_right (
        .approaching(dx_right), .ball_x(bx), .ball_y(by), .paddle_y(p2y), .hit(hit_r)
    );

    // The two axes resolve independently, so a wall and a paddle bounce can share a tick.
    always_comb begin
        y_next  = by;
        dy_next = dy_down;
        x_next  = bx;
        dx_next = dx_right;
        miss_l  = !dx_right && (bx < BALL_SPEED);
        miss_r  = dx_right && (bx + BALL_SIZE + BALL_SPEED > SCREEN_W);
        if (!dy_down) begin
            if (by < BALL_SPEED) begin
                y_next  = '0;
                dy_next = 1'b1;
            end else begin
                y_next = by - BALL_SPEED;
            end
        end else if (by + BALL_SIZE + BALL_SPEED > SCREEN_H) begin
            y_next  = SCREEN_H - BALL_SIZE;
            dy_next = 1'b0;
        end else begin
            y_next = by + BALL_SPEED;
        end
        if (hit_l) begin
            x_next  = P1_X + PADDLE_W;
            dx_next = 1'b1;
        end else if (hit_r) begin
            x_next  = P2_X - BALL_SIZE;
            dx_next = 1'b0;
        end else if (dx_right) begin
            x_next = bx + BALL_SPEED;
        end else begin
            x_next = bx - BALL_SPEED;
        end
        p1_inc = (p1_score == WIN_SCORE) ? p1_score : p1_score + 4'd1;
        p2_inc = (p2_score == WIN_SCORE) ? p2_score : p2_score + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= QI;
            ball_x      <= 11'(BALL_X0);
            ball_y      <= 10'(BALL_Y0);
            p1_score    <= '0;
            p2_score    <= '0;
            score_pulse <= 1'b0;
            dx_right    <= 1'b1;
            dy_down     <= 1'b0;
            serve_cnt   <= '0;
        end else begin
            score_pulse <= 1'b0;
            case (state_q)
                QI: begin
                    ball_x   <= 11'(BALL_X0);
                    ball_y   <= 10'(BALL_Y0);
                    p1_score <= '0;
                    p2_score <= '0;
                    if (start) begin
                        state_q   <= QGAME_1;
                        dx_right  <= 1'b1;
                        dy_down   <= 1'b0;
                        serve_cnt <= '0;
                    end
                end
                QGAME_1: begin
                    ball_x <= 11'(BALL_X0);
                    ball_y <= 10'(BALL_Y0);
                    if (!start) begin
                        state_q  <= QI;
                        p1_score <= '0;
                        p2_score <= '0;
                    end else if (frame_tick) begin
                        if (serve_cnt == SERVE_FRAMES - 6'd1)
                            state_q <= QGAME_2;
                        else
                            serve_cnt <= serve_cnt + 6'd1;
                    end
                end
                QGAME_2: begin
                    if (!start) begin
                        state_q  <= QI;
                        ball_x   <= 11'(BALL_X0);
                        ball_y   <= 10'(BALL_Y0);
                        p1_score <= '0;
                        p2_score <= '0;
                    end else if (frame_tick) begin
                        // A paddle hit always wins over a miss on the same tick.
                        if (!hit_l && !hit_r && (miss_l || miss_r)) begin
                            score_pulse <= 1'b1;
                            ball_x      <= 11'(BALL_X0);
                            ball_y      <= 10'(BALL_Y0);
                            dy_down     <= 1'b0;
                            serve_cnt   <= '0;
                            if (miss_r) begin
                                p1_score <= p1_inc;
                                dx_right <= 1'b1;
                                state_q  <= (p1_inc == WIN_SCORE) ? QDONE : QGAME_1;
                            end else begin
                                p2_score <= p2_inc;
                                dx_right <= 1'b0;
                                state_q  <= (p2_inc == WIN_SCORE) ? QDONE : QGAME_1;
                            end
                        end else begin
                            ball_x   <= 11'(x_next);
                            ball_y   <= 10'(y_next);
                            dx_right <= dx_next;
                            dy_down  <= dy_next;
                        end
                    end
                end
                QDONE: begin
                    if (!start) begin
                        state_q  <= QI;
                        ball_x   <= 11'(BALL_X0);
                        ball_y   <= 10'(BALL_Y0);
                        p1_score <= '0;
                        p2_score <= '0;
                    end
                end
                default: state_q <= QI;
            endcase
        end
    end

endmodule
